// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock supervisor and downstream reset sequencer
//
// Drives the PLL reset, waits for lock with a per-attempt timeout and a bounded
// number of attempts, and requires lock to hold continuously before releasing
// the system reset. Loss of lock in RUN re-resets the PLL and is counted.
//
// Ports:
//   refclk        in   sole clock, rising edge
//   rst           in   synchronous active-high reset
//   pll_locked    in   PLL lock indication, asynchronous to refclk
//   pll_rst       out  reset to the PLL
//   sys_rst       out  reset to PLL-clocked logic, active high
//   ready         out  high only in RUN
//   fault         out  high only in FAULT
//   relock_count  out  saturating count of lock losses seen in RUN

module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_ATTEMPTS        = 3,
  parameter int SYNC_STAGES         = 2
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] relock_count
);

  // One shared counter serves all timed states, so size it for the longest.
  localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int ATT_W     = $clog2(MAX_ATTEMPTS + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [ATT_W-1:0] ATT_LIMIT    = ATT_W'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic [ATT_W-1:0]       att, att_next;
  logic [ATT_W-1:0]       att_inc;
  logic [7:0]             relock_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_s;

  // Lock synchronizer; the FSM never looks at raw pll_locked.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync[SYNC_STAGES-1];
  assign att_inc  = att + ATT_W'(1);

  always_ff @(posedge refclk) begin
    if (rst) begin
      state        <= PLL_RESET;
      cnt          <= '0;
      att          <= '0;
      relock_count <= '0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      att          <= att_next;
      relock_count <= relock_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt + CNT_W'(1);
    att_next    = att;
    relock_next = relock_count;
    case (state)
      PLL_RESET: begin
        if (cnt == RST_LAST) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a timeout expiring on the same cycle.
        if (locked_s) begin
          state_next = STABLE;
          cnt_next   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          att_next   = att_inc;
          cnt_next   = '0;
          state_next = (att_inc == ATT_LIMIT) ? FAULT : PLL_RESET;
        end
      end
      STABLE: begin
        // Any dropout restarts the lock wait without consuming an attempt.
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
          att_next   = '0;
        end
      end
      RUN: begin
        cnt_next = '0;
        if (!locked_s) begin
          state_next = PLL_RESET;
          if (relock_count != 8'hff) begin
            relock_next = relock_count + 8'd1;
          end
        end
      end
      FAULT: begin
        cnt_next = '0;
      end
      default: begin
        state_next = PLL_RESET;
        cnt_next   = '0;
      end
    endcase
  end

  // Moore decode straight off the state register.
  assign pll_rst = (state == PLL_RESET);
  assign sys_rst = (state != RUN);
  assign ready   = (state == RUN);
  assign fault   = (state == FAULT);

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer

module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [7:0] relock_count;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .STABLE_CYCLES       (8),
    .MAX_ATTEMPTS        (2),
    .SYNC_STAGES         (2)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .fault        (fault),
    .relock_count (relock_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Edge counter: after rising edge n, cyc == n.
  int cyc = 0;
  always @(posedge refclk) cyc = cyc + 1;

  // Expected output-vector changes {pll_rst, sys_rst, ready, fault, relock_count}
  // and the edge after which each must first be visible.
  typedef struct {
    int          cyc;
    logic [11:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  function automatic logic [11:0] o(input logic pr, input logic sr, input logic rd,
                                    input logic ft, input logic [7:0] rc);
    return {pr, sr, rd, ft, rc};
  endfunction

  function automatic logic [7:0] sat(input int n);
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  task automatic push(input int c, input logic [11:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge refclk);
  endtask

  // Monitor: every change of the output vector must match the next expected entry.
  logic [11:0] prev = 'x;
  logic [11:0] cur;
  always @(negedge refclk) begin
    exp_t e;
    cur = {pll_rst, sys_rst, ready, fault, relock_count};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      total = total + 1;
      $display("FAIL missed_event: expected %h at edge %0d, output still %h at edge %0d",
               exp_q[0].val, exp_q[0].cyc, cur, cyc);
      void'(exp_q.pop_front());
    end
    if (cur !== prev) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_change: got %h at edge %0d, required no change (was %h)",
                 cur, cyc, prev);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc == cyc && e.val === cur) begin
          passed = passed + 1;
        end else begin
          $display("FAIL output_change: got %h at edge %0d, required %h at edge %0d",
                   cur, cyc, e.val, e.cyc);
        end
      end
      prev = cur;
    end
  end

  initial begin
    int t;
    int r;
    rst        = 1'b1;
    pll_locked = 1'b0;

    // Reset state and nominal bring-up.
    push(1, o(1, 1, 0, 0, 8'd0));
    wait_cyc(3);
    rst = 1'b0;
    r   = 3;
    push(r + 4,  o(0, 1, 0, 0, 8'd0));
    push(r + 21, o(0, 0, 1, 0, 8'd0));
    wait_cyc(r + 10);
    pll_locked = 1'b1;
    wait_cyc(r + 21);

    // Repeated loss of lock in RUN; relock_count saturates at 255.
    for (int n = 1; n <= 300; n++) begin
      t = cyc;
      push(t + 3,  o(1, 1, 0, 0, sat(n)));
      push(t + 7,  o(0, 1, 0, 0, sat(n)));
      push(t + 18, o(0, 0, 1, 0, sat(n)));
      pll_locked = 1'b0;
      wait_cyc(t + 7);
      pll_locked = 1'b1;
      wait_cyc(t + 18);
    end

    // One more loss, then reset asserted while in STABLE.
    t = cyc;
    push(t + 3, o(1, 1, 0, 0, 8'd255));
    push(t + 7, o(0, 1, 0, 0, 8'd255));
    pll_locked = 1'b0;
    wait_cyc(t + 7);
    pll_locked = 1'b1;
    wait_cyc(t + 12);
    rst        = 1'b1;
    pll_locked = 1'b0;
    push(t + 13, o(1, 1, 0, 0, 8'd0));
    wait_cyc(t + 14);
    rst = 1'b0;
    r   = t + 14;

    // Two-cycle lock glitch while in STABLE: back to WAIT_LOCK, no PLL reset.
    push(r + 4,  o(0, 1, 0, 0, 8'd0));
    push(r + 29, o(0, 0, 1, 0, 8'd0));
    wait_cyc(r + 10);
    pll_locked = 1'b1;
    wait_cyc(r + 16);
    pll_locked = 1'b0;
    wait_cyc(r + 18);
    pll_locked = 1'b1;
    wait_cyc(r + 29);

    // Lock coincides with timeout expiry: lock wins and the attempt is not
    // consumed, so a later timeout retries instead of faulting.
    t = cyc;
    rst        = 1'b1;
    pll_locked = 1'b0;
    push(t + 1, o(1, 1, 0, 0, 8'd0));
    wait_cyc(t + 2);
    rst = 1'b0;
    r   = t + 2;
    push(r + 4,  o(0, 1, 0, 0, 8'd0));
    push(r + 47, o(1, 1, 0, 0, 8'd0));
    push(r + 51, o(0, 1, 0, 0, 8'd0));
    push(r + 62, o(0, 0, 1, 0, 8'd0));
    wait_cyc(r + 21);
    pll_locked = 1'b1;
    wait_cyc(r + 24);
    pll_locked = 1'b0;
    wait_cyc(r + 51);
    pll_locked = 1'b1;
    wait_cyc(r + 62);

    // No lock at all: two pulses, FAULT at edge 48, then reset out of FAULT.
    t = cyc;
    rst        = 1'b1;
    pll_locked = 1'b0;
    push(t + 1, o(1, 1, 0, 0, 8'd0));
    wait_cyc(t + 2);
    rst = 1'b0;
    r   = t + 2;
    push(r + 4,  o(0, 1, 0, 0, 8'd0));
    push(r + 24, o(1, 1, 0, 0, 8'd0));
    push(r + 28, o(0, 1, 0, 0, 8'd0));
    push(r + 48, o(0, 1, 0, 1, 8'd0));
    wait_cyc(r + 60);
    rst = 1'b1;
    push(r + 61, o(1, 1, 0, 0, 8'd0));
    wait_cyc(r + 62);
    rst = 1'b0;
    r   = r + 62;
    push(r + 4,  o(0, 1, 0, 0, 8'd0));
    push(r + 21, o(0, 0, 1, 0, 8'd0));
    wait_cyc(r + 10);
    pll_locked = 1'b1;
    wait_cyc(r + 30);

    total = total + 1;
    if (exp_q.size() == 0) begin
      passed = passed + 1;
    end else begin
      $display("FAIL scoreboard_drain: %0d expected events left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Lock supervisor and reset sequencer for the fabric PLL, running in the PLL's reference clock domain. It drives the PLL reset, waits for lock with a timeout and a bounded number of retries, and requires lock to hold continuously before it releases the downstream system reset. It also detects loss of lock, re-resets the PLL, counts relock events and latches a fault when lock cannot be achieved. It sits between the board reset and the PLL-driven core logic.

## Interface
Parameters:
- RST_PULSE_CYCLES, 16: cycles pll_rst is held high per PLL reset attempt (>=1)
- LOCK_TIMEOUT_CYCLES, 50000: cycles allowed in WAIT_LOCK per attempt (1 ms at 50 MHz, >=1)
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (>=1)
- MAX_ATTEMPTS, 3: total lock attempts before FAULT (>=1)
- SYNC_STAGES, 2: flip-flop stages on pll_locked (>=2)

Ports:
- refclk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pll_locked  in  1  PLL locked, asynchronous to refclk
- pll_rst  out  1  reset to PLL
- sys_rst  out  1  reset to PLL-clocked logic, active high
- ready  out  1  high only in RUN
- fault  out  1  high only in FAULT
- relock_count  out  8  saturating count of lock losses seen in RUN

## Operation
- pll_locked passes through a SYNC_STAGES flop chain; its output is locked_s. The FSM only uses locked_s.
- States: PLL_RESET, WAIT_LOCK, STABLE, RUN, FAULT. One counter cnt, cleared on every state entry. One attempt counter att.
- Outputs are a Moore decode of the state register:
  - PLL_RESET: pll_rst=1, sys_rst=1.
  - WAIT_LOCK and STABLE: pll_rst=0, sys_rst=1.
  - RUN: pll_rst=0, sys_rst=0, ready=1.
  - FAULT: pll_rst=0, sys_rst=1, fault=1.
- Reset: state=PLL_RESET, cnt=0, att=0, relock_count=0, sync chain cleared.
  - Reset values of the outputs are pll_rst=1, sys_rst=1, ready=0, fault=0, relock_count=0.
- PLL_RESET: cnt increments each cycle. At cnt==RST_PULSE_CYCLES-1 the FSM moves to WAIT_LOCK.
- WAIT_LOCK:
  - locked_s=1 moves the FSM to STABLE.
  - Otherwise, at cnt==LOCK_TIMEOUT_CYCLES-1, att increments. If the new att equals MAX_ATTEMPTS the FSM moves to FAULT, otherwise to PLL_RESET.
  - If locked_s=1 on the expiry cycle, lock wins: the FSM goes to STABLE and att does not change.
- STABLE:
  - locked_s=0 returns the FSM to WAIT_LOCK with a fresh timeout; att is unchanged.
  - Otherwise cnt increments. At cnt==STABLE_CYCLES-1 the FSM moves to RUN and att clears.
- RUN: locked_s=0 moves the FSM to PLL_RESET and increments relock_count, saturating at 255.
- FAULT: terminal; only rst leaves it.
- rst in any state overrides everything on that edge, including mid-pulse and mid-count.

## Timing
- Each PLL reset attempt holds pll_rst high for exactly RST_PULSE_CYCLES cycles. After rst, pll_rst stays high for all rst cycles plus RST_PULSE_CYCLES.
- WAIT_LOCK without lock lasts exactly LOCK_TIMEOUT_CYCLES cycles.
- Let edge k be the first edge that samples pll_locked=1 while in WAIT_LOCK, with lock held. Then:
  - STABLE is entered at edge k+SYNC_STAGES.
  - RUN is entered, and sys_rst falls with ready rising, at edge k+SYNC_STAGES+STABLE_CYCLES.
- Loss of lock in RUN: let edge j be the first edge that samples pll_locked=0. sys_rst rises and ready falls at edge j+SYNC_STAGES, and relock_count updates on the same edge.
- Glitches on pll_locked shorter than one cycle may be missed; this is accepted.

## Test plan
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, MAX_ATTEMPTS=2, SYNC_STAGES=2.
- Nominal bring-up:
  - Stimulus: rst high 3 cycles; pll_locked rises 10 cycles after rst falls and stays high.
  - Required: pll_rst high during rst plus 4 cycles; ready=1 and sys_rst=0 exactly 10 edges after the first edge sampling lock; fault=0; relock_count=0.
- No lock:
  - Stimulus: pll_locked held 0.
  - Required: two 4-cycle pll_rst pulses separated by 20 cycles; fault=1 at edge 48 after rst release; pll_rst=0 and sys_rst=1 thereafter.
- Lock glitch in STABLE:
  - Stimulus: pll_locked drops for 2 cycles at STABLE cnt=5.
  - Required: return to WAIT_LOCK; after lock is restored, ready rises SYNC_STAGES+8 edges later; no pll_rst pulse; relock_count=0.
- Loss in RUN:
  - Stimulus: drop pll_locked in RUN.
  - Required: sys_rst=1 two edges later; 4-cycle pll_rst pulse; relock_count=1; RUN regained after relock.
  - Repeat 300 times: relock_count saturates at 255.
- Simultaneous lock and timeout:
  - Stimulus: locked_s rises on the edge where the WAIT_LOCK cnt reaches 19.
  - Required: STABLE entered; no retry; att unchanged.
- Reset mid-operation:
  - Stimulus: assert rst in STABLE; separately, assert rst in FAULT.
  - Required: next edge gives pll_rst=1, sys_rst=1, ready=0, fault=0, relock_count=0; bring-up then restarts.
